// File: rtl/inst_sram_responder.sv
// Instruction SRAM target: front-door read/byte-write, backdoor preload, range-error capture, access counters.
// Latency: read data registered one cycle after request; no backpressure, rdata holds while idle.
module inst_sram_responder #(
    parameter int          ADDR_WIDTH = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h1C000000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  sram_en,
    input  logic [3:0]            sram_wen,
    input  logic [31:0]           sram_addr,
    input  logic [31:0]           sram_wdata,
    output logic [31:0]           sram_rdata,
    input  logic                  bd_en,
    input  logic [3:0]            bd_wen,
    input  logic [ADDR_WIDTH-1:0] bd_addr,
    input  logic [31:0]           bd_wdata,
    output logic                  err_flag,
    output logic [31:0]           err_addr,
    output logic [31:0]           rd_cnt,
    output logic [31:0]           wr_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  fd_act;
    logic                  fd_rd;
    logic                  fd_wr;
    logic                  fd_oor;
    logic                  unused_addr_lsb;

    assign in_range = (sram_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign idx      = sram_addr[ADDR_WIDTH+1:2];

    // Backdoor wins: any front-door request in the same cycle is dropped entirely.
    assign fd_act = resetn && sram_en && !bd_en;
    assign fd_rd  = fd_act && in_range && (sram_wen == 4'b0000);
    assign fd_wr  = fd_act && in_range && (sram_wen != 4'b0000);
    assign fd_oor = fd_act && !in_range;

    assign unused_addr_lsb = &{1'b0, sram_addr[1:0]};

    // Array has no reset so its contents survive a core reset.
    always_ff @(posedge clk) begin
        if (bd_en) begin
            for (int i = 0; i < 4; i++) begin
                if (bd_wen[i]) begin
                    mem[bd_addr][8*i +: 8] <= bd_wdata[8*i +: 8];
                end
            end
        end else if (fd_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (sram_wen[i]) begin
                    mem[idx][8*i +: 8] <= sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sram_rdata <= 32'h0;
            err_flag   <= 1'b0;
            err_addr   <= 32'h0;
            rd_cnt     <= 32'h0;
            wr_cnt     <= 32'h0;
        end else begin
            // Writes return the pre-write word (read-first).
            if (fd_rd || fd_wr) begin
                sram_rdata <= mem[idx];
            end else if (fd_oor) begin
                sram_rdata <= 32'h0;
            end

            if (fd_rd && (rd_cnt != 32'hFFFF_FFFF)) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (fd_wr && (wr_cnt != 32'hFFFF_FFFF)) begin
                wr_cnt <= wr_cnt + 32'd1;
            end

            if (fd_oor) begin
                err_flag <= 1'b1;
                if (!err_flag) begin
                    err_addr <= sram_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Directed bench for inst_sram_responder: per-cycle comparison against a word-level memory model
// plus literal expectations taken from the worked examples.
module tb_inst_sram_responder;

    localparam int          AW   = 14;
    localparam logic [31:0] BASE = 32'h1C000000;
    localparam logic [31:0] SPAN = 32'h4 << AW;

    logic          clk = 1'b0;
    logic          resetn;
    logic          sram_en;
    logic [3:0]    sram_wen;
    logic [31:0]   sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;
    logic          bd_en;
    logic [3:0]    bd_wen;
    logic [AW-1:0] bd_addr;
    logic [31:0]   bd_wdata;
    logic          err_flag;
    logic [31:0]   err_addr;
    logic [31:0]   rd_cnt;
    logic [31:0]   wr_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic [31:0] m_mem [int];
    logic [31:0] m_rdata;
    logic        m_err;
    logic [31:0] m_err_addr;
    logic [31:0] m_rd;
    logic [31:0] m_wr;

    inst_sram_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .bd_en      (bd_en),
        .bd_wen     (bd_wen),
        .bd_addr    (bd_addr),
        .bd_wdata   (bd_wdata),
        .err_flag   (err_flag),
        .err_addr   (err_addr),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int w);
        if (m_mem.exists(w)) return m_mem[w];
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_rdata    = 32'h0;
        m_err      = 1'b0;
        m_err_addr = 32'h0;
        m_rd       = 32'h0;
        m_wr       = 32'h0;
    endtask

    // Applies the effect of one rising edge, using the inputs held across it.
    task automatic model_step();
        int w;
        if (!resetn) begin
            model_reset();
            if (bd_en) m_mem[int'(bd_addr)] = merge(m_read(int'(bd_addr)), bd_wdata, bd_wen);
        end else if (bd_en) begin
            m_mem[int'(bd_addr)] = merge(m_read(int'(bd_addr)), bd_wdata, bd_wen);
        end else if (sram_en) begin
            if (sram_addr >= BASE && sram_addr < BASE + SPAN) begin
                w = int'((sram_addr - BASE) >> 2);
                m_rdata = m_read(w);
                if (sram_wen == 4'b0000) begin
                    if (m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 1;
                end else begin
                    m_mem[w] = merge(m_rdata, sram_wdata, sram_wen);
                    if (m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
                end
            end else begin
                m_rdata = 32'h0;
                if (!m_err) m_err_addr = sram_addr;
                m_err = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("rdata",    sram_rdata,        m_rdata);
        check("err_flag", {31'h0, err_flag}, {31'h0, m_err});
        check("err_addr", err_addr,          m_err_addr);
        check("rd_cnt",   rd_cnt,            m_rd);
        check("wr_cnt",   wr_cnt,            m_wr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_in();
        sram_en = 1'b0; sram_wen = 4'h0; sram_addr = 32'h0; sram_wdata = 32'h0;
        bd_en = 1'b0; bd_wen = 4'h0; bd_addr = '0; bd_wdata = 32'h0;
    endtask

    task automatic fd(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        clear_in();
        sram_en = 1'b1; sram_addr = a; sram_wen = be; sram_wdata = d;
        tick();
    endtask

    task automatic bd(input logic [AW-1:0] a, input logic [31:0] d);
        clear_in();
        bd_en = 1'b1; bd_addr = a; bd_wen = 4'hF; bd_wdata = d;
        tick();
    endtask

    task automatic idle();
        clear_in();
        tick();
    endtask

    initial begin
        clear_in();
        model_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        compare_all();
        check("reset_rdata_lit", sram_rdata, 32'h0);

        // Preload while core held in reset.
        bd(0, 32'h02800C21);
        bd(1, 32'h1C000000);
        bd(2, 32'h00000000);
        bd(3, 32'h00000000);
        resetn = 1'b1;
        idle();

        fd(32'h1C000000, 4'h0, 32'h0);
        check("boot_rd0_lit", sram_rdata, 32'h02800C21);
        fd(32'h1C000004, 4'h0, 32'h0);
        check("boot_rd1_lit", sram_rdata, 32'h1C000000);
        idle();
        check("boot_rdcnt_lit", rd_cnt, 32'd2);

        // Hold behaviour while the fetch stage stalls.
        bd(0, 32'h11223344);
        fd(32'h1C000000, 4'h0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            idle();
            check("hold_lit", sram_rdata, 32'h11223344);
        end

        fd(32'h1C000008, 4'b0101, 32'hAABBCCDD);
        check("wr_readfirst_lit", sram_rdata, 32'h00000000);
        fd(32'h1C000008, 4'h0, 32'h0);
        check("wr_merge_lit", sram_rdata, 32'h00BB00DD);
        check("wr_cnt_lit", wr_cnt, 32'd1);
        check("rd_cnt4_lit", rd_cnt, 32'd4);

        // Back-to-back write then read of the same word.
        fd(32'h1C000010, 4'hF, 32'hCAFEF00D);
        fd(32'h1C000010, 4'h0, 32'h0);
        check("b2b_lit", sram_rdata, 32'hCAFEF00D);

        fd(32'h1C010000, 4'h0, 32'h0);
        check("oor_rdata_lit", sram_rdata, 32'h0);
        check("oor_flag_lit", {31'h0, err_flag}, 32'h1);
        fd(32'h20000000, 4'hF, 32'h55555555);
        check("oor_first_lit", err_addr, 32'h1C010000);
        check("oor_rdcnt_lit", rd_cnt, 32'd5);
        check("oor_wrcnt_lit", wr_cnt, 32'd2);

        // Backdoor and front-door write in the same cycle.
        fd(32'h1C000000, 4'h0, 32'h0);
        clear_in();
        bd_en = 1'b1; bd_addr = 3; bd_wen = 4'hF; bd_wdata = 32'hDEADBEEF;
        sram_en = 1'b1; sram_addr = 32'h1C00000C; sram_wen = 4'hF; sram_wdata = 32'h12345678;
        tick();
        check("bdprio_rdata_lit", sram_rdata, 32'h11223344);
        check("bdprio_wrcnt_lit", wr_cnt, 32'd2);
        fd(32'h1C00000C, 4'h0, 32'h0);
        check("bdprio_mem_lit", sram_rdata, 32'hDEADBEEF);

        // Asynchronous reset between edges; array must survive.
        clear_in();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check("areset_rdata_lit", sram_rdata, 32'h0);
        check("areset_err_lit", {31'h0, err_flag}, 32'h0);
        check("areset_eaddr_lit", err_addr, 32'h0);
        check("areset_rd_lit", rd_cnt, 32'h0);
        check("areset_wr_lit", wr_cnt, 32'h0);
        @(negedge clk);
        compare_all();
        resetn = 1'b1;
        fd(32'h1C00000C, 4'h0, 32'h0);
        check("post_reset_mem_lit", sram_rdata, 32'hDEADBEEF);
        check("post_reset_rd_lit", rd_cnt, 32'd1);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
